debouncer: RTL and testbench
============================

Name: debouncer

Overview:
- Single-bit, clock-synchronous debouncer/glitch filter.
- Output follows the input only after the input has differed from the current output for 2^p_CNT_WIDTH consecutive rising clock edges.
- Shorter excursions are suppressed entirely.
- Sits after an external synchronizer on mechanical switch/button or noisy control lines.

Parameters:
- p_CNT_WIDTH, default 2: stability counter width; tolerance period T = 2^p_CNT_WIDTH clock cycles (default 4). Legal range 1..16.
- p_INIT_VALUE, default 1'b0: value loaded into the output on reset.

Ports:
- i_clk, input, 1: clock; all state updates on the rising edge.
- i_rst, input, 1: synchronous, active-high reset.
- i_in, input, 1: raw (already clock-domain-synchronized) input.
- o_out, output, 1: debounced output; driven directly from a register.

Behaviour:
- State: o_out register, plus a stability counter r_cnt of p_CNT_WIDTH bits.
- Reset: on a rising edge with i_rst=1, o_out <= p_INIT_VALUE and r_cnt <= 0. Reset has priority over everything else. Reset mid-count discards progress.
- Each rising edge with i_rst=0:
  - i_in == o_out: r_cnt <= 0; o_out unchanged.
  - i_in != o_out and r_cnt != 2^p_CNT_WIDTH-1: r_cnt <= r_cnt+1; o_out unchanged.
  - i_in != o_out and r_cnt == 2^p_CNT_WIDTH-1: o_out <= i_in; r_cnt <= 0.
- Latency: if i_in changes before rising edge k and stays stable, o_out takes the new value at edge k+T-1. This is the T-th sampling edge and is visible immediately after it.
- No extra input flops are inserted; latency is exactly T sampling edges.
- Filtering:
  - Any run where i_in differs from o_out for at most T-1 consecutive sampling edges produces no change on o_out, not even a glitch.
  - Includes toggling every cycle, every T/2 cycles, and every T-1 cycles.
- Counter never wraps: it is cleared on acceptance, or whenever the input matches the output.
- o_out changes only at rising edges of i_clk; it is a glitch-free register output.
- After an accepted change, a return to the old value again needs T consecutive differing edges.
- Simultaneous i_rst=1 with a pending acceptance: reset wins, o_out = p_INIT_VALUE.
- No combinational path from i_in to o_out.

Test Plan (p_CNT_WIDTH=2, T=4, p_INIT_VALUE=0; input driven on falling edges):
- Reset: assert i_rst for 2 cycles with i_in=1 -> o_out=0 throughout and after release; with p_INIT_VALUE=1, o_out=1 after reset.
- Every-cycle toggling: toggle i_in every cycle for 12 cycles -> o_out never changes (stays 0).
- Sub-tolerance pulses: toggle i_in every 2 cycles, then every 3 cycles, 12 toggles each -> o_out never changes.
- Acceptance timing:
  - Set i_in=1 and hold -> o_out still 0 after rising edges 1, 2 and 3.
  - o_out=1 after edge 4.
  - Repeat with i_in=0 -> o_out returns to 0 after exactly 4 edges.
  - Alternate 12 times at 4-cycle spacing: o_out equals i_in each time, sampled one falling edge after the 4th edge.
- Counter clear: i_in=1 for 3 edges, 0 for 1 edge, then 1 held -> o_out rises only on the 4th edge after the final change (7 edges of 1 total, no early switch).
- Reset mid-count: i_in=1 for 3 edges, then i_rst=1 on the 4th edge -> o_out stays 0; after release with i_in=1, a full 4 new edges are required before o_out=1.

Source files
------------

// File: rtl/debouncer.sv
// Single-bit glitch filter: o_out adopts i_in only after 2^p_CNT_WIDTH consecutive differing edges.
// Latency is exactly T sampling edges from the change; no input flops and no backpressure.
module debouncer #(
  parameter int unsigned p_CNT_WIDTH  = 2,
  parameter logic        p_INIT_VALUE = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_in,
  output logic o_out
);

  logic [p_CNT_WIDTH-1:0] r_cnt;
  logic                   differ;
  logic                   expired;

  assign differ  = i_in ^ o_out;
  // All-ones means this edge is the T-th consecutive differing sample.
  assign expired = &r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_out <= p_INIT_VALUE;
      r_cnt <= '0;
    end else if (!differ) begin
      r_cnt <= '0;
    end else if (expired) begin
      o_out <= i_in;
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_debouncer.sv
// Bench for debouncer (T=4): directed scenarios plus random runs against a sample-window model.
module tb_debouncer;

  localparam int CW = 2;
  localparam int T  = 1 << CW;

  logic clk = 1'b0;
  logic rst;
  logic din;
  logic dout;
  logic dout_hi;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  debouncer #(.p_CNT_WIDTH(CW), .p_INIT_VALUE(1'b0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_in(din), .o_out(dout)
  );

  debouncer #(.p_CNT_WIDTH(CW), .p_INIT_VALUE(1'b1)) u_dut_hi (
    .i_clk(clk), .i_rst(rst), .i_in(din), .o_out(dout_hi)
  );

  // Reference: output takes the input once the last T samples since the
  // previous reset/acceptance all disagree with the current output.
  logic m_out = 1'b0;
  bit   hist[$];

  always @(posedge clk) begin
    if (rst) begin
      m_out = 1'b0;
      hist.delete();
    end else begin
      bit all_diff;
      hist.push_back(din);
      if (hist.size() > T) void'(hist.pop_front());
      all_diff = (hist.size() == T);
      foreach (hist[i]) if (hist[i] == m_out) all_diff = 1'b0;
      if (all_diff) begin
        m_out = din;
        hist.delete();
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic settle_low();
    rst = 1'b0;
    din = 1'b0;
    for (int i = 0; i < T + 1; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (dout !== 1'b0) begin
        errors++;
        $display("FAIL reset_lo cyc%0d got %b want 0", i, dout);
      end
      checks++;
      if (dout_hi !== 1'b1) begin
        errors++;
        $display("FAIL reset_hi cyc%0d got %b want 1", i, dout_hi);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (dout !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got %b want 0", dout);
    end
    settle_low();
  endtask

  task automatic test_toggle();
    for (int i = 0; i < 12; i++) begin
      din = ~din;
      tick();
      checks++;
      if (dout !== 1'b0 || dout !== m_out) begin
        errors++;
        $display("FAIL toggle cyc%0d got %b want 0", i, dout);
      end
    end
    settle_low();
  endtask

  task automatic test_sub_tolerance();
    for (int per = 2; per <= 3; per++) begin
      for (int t = 0; t < 12; t++) begin
        din = ~din;
        for (int c = 0; c < per; c++) begin
          tick();
          checks++;
          if (dout !== 1'b0) begin
            errors++;
            $display("FAIL subtol_p%0d tog%0d got %b want 0", per, t, dout);
          end
        end
      end
      settle_low();
    end
  endtask

  task automatic test_accept();
    din = 1'b1;
    for (int e = 1; e <= T; e++) begin
      tick();
      checks++;
      if (dout !== (e == T)) begin
        errors++;
        $display("FAIL accept_rise e%0d got %b want %b", e, dout, e == T);
      end
    end
    din = 1'b0;
    for (int e = 1; e <= T; e++) begin
      tick();
      checks++;
      if (dout !== (e < T)) begin
        errors++;
        $display("FAIL accept_fall e%0d got %b want %b", e, dout, e < T);
      end
    end
    for (int k = 0; k < 12; k++) begin
      logic prev;
      prev = din;
      din = ~din;
      for (int e = 1; e <= T; e++) begin
        tick();
        checks++;
        if (dout !== ((e == T) ? din : prev)) begin
          errors++;
          $display("FAIL accept_alt k%0d e%0d got %b want %b", k, e, dout,
                   (e == T) ? din : prev);
        end
      end
    end
    settle_low();
  endtask

  task automatic test_counter_clear();
    din = 1'b1;
    for (int e = 0; e < 3; e++) tick();
    din = 1'b0;
    tick();
    checks++;
    if (dout !== 1'b0) begin
      errors++;
      $display("FAIL clear_dip got %b want 0", dout);
    end
    din = 1'b1;
    for (int e = 1; e <= T; e++) begin
      tick();
      checks++;
      if (dout !== (e == T)) begin
        errors++;
        $display("FAIL clear_hold e%0d got %b want %b", e, dout, e == T);
      end
    end
    settle_low();
  endtask

  task automatic test_reset_mid();
    din = 1'b1;
    for (int e = 0; e < 3; e++) tick();
    rst = 1'b1;
    tick();
    checks++;
    if (dout !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_win got %b want 0", dout);
    end
    rst = 1'b0;
    for (int e = 1; e <= T; e++) begin
      tick();
      checks++;
      if (dout !== (e == T)) begin
        errors++;
        $display("FAIL rstmid_after e%0d got %b want %b", e, dout, e == T);
      end
    end
    settle_low();
  endtask

  task automatic test_random();
    int run;
    run = 0;
    for (int i = 0; i < 600; i++) begin
      if (run == 0) begin
        din = ~din;
        run = $urandom_range(1, 6);
      end
      run--;
      rst = ($urandom_range(0, 49) == 0);
      tick();
      checks++;
      if (dout !== m_out) begin
        errors++;
        $display("FAIL random cyc%0d got %b want %b", i, dout, m_out);
      end
    end
    settle_low();
  endtask

  initial begin
    rst = 1'b1;
    din = 1'b0;
    tick();
    test_reset();
    test_toggle();
    test_sub_tolerance();
    test_accept();
    test_counter_clear();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
